// File: rtl/hc595_chain_display_driver.sv
// Serialises NUM_DIGITS seven-segment bytes into a chain of 74HC595 registers
// and latches them together with a single RCLK pulse.
module hc595_chain_display_driver #(
   parameter int NUM_DIGITS   = 4,
   parameter int CLK_DIV      = 4,
   parameter int COMMON_ANODE = 0
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      start,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     dp,
   input  logic                      blank,
   output logic                      busy,
   output logic                      done,
   output logic                      SER,
   output logic                      SRCLK,
   output logic                      RCLK,
   output logic                      SRCLRbar,
   output logic                      OEbar
);

   localparam int NBITS = 8 * NUM_DIGITS;
   localparam int DIV_W = $clog2(2 * CLK_DIV + 1);
   localparam int BIT_W = $clog2(NBITS + 1);

   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_HALF   = DIV_W'(CLK_DIV);
   localparam logic [DIV_W-1:0] LATCH_LAST = DIV_W'(2 * CLK_DIV - 1);
   localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(NBITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_SHIFT_LO,
      S_SHIFT_HI,
      S_LATCH,
      S_DONE
   } state_t;

   state_t                    r_state;
   state_t                    w_state_next;
   logic [DIV_W-1:0]          r_div;
   logic [DIV_W-1:0]          w_div_next;
   logic [BIT_W-1:0]          r_bit;
   logic [BIT_W-1:0]          w_bit_next;
   logic [NBITS-1:0]          r_frame;
   logic [NBITS-1:0]          w_frame_next;
   logic [NBITS-1:0]          w_enc_frame;
   logic [4*NUM_DIGITS-1:0]   r_dig_cap;
   logic [NUM_DIGITS-1:0]     r_dp_cap;
   logic                      w_capture;

   logic r_ser, r_srclk, r_rclk, r_busy, r_done, r_srclr_n, r_oe_n;
   logic w_ser_next, w_srclk_next, w_rclk_next, w_busy_next, w_done_next;

   // Segment byte: bit7=a .. bit1=g, bit0=dp; common-anode parts take the complement.
   function automatic logic [7:0] seg_encode(input logic [3:0] v, input logic d);
      logic [7:0] seg;
      case (v)
         4'h0:    seg = 8'hFC;
         4'h1:    seg = 8'h60;
         4'h2:    seg = 8'hDA;
         4'h3:    seg = 8'hF2;
         4'h4:    seg = 8'h66;
         4'h5:    seg = 8'hB6;
         4'h6:    seg = 8'hBE;
         4'h7:    seg = 8'hE0;
         4'h8:    seg = 8'hFE;
         4'h9:    seg = 8'hE6;
         4'hA:    seg = 8'hEE;
         4'hB:    seg = 8'h3E;
         4'hC:    seg = 8'h9C;
         4'hD:    seg = 8'h7A;
         4'hE:    seg = 8'h9E;
         default: seg = 8'h8E;
      endcase
      seg[0] = seg[0] | d;
      if (COMMON_ANODE != 0) begin
         seg = ~seg;
      end
      return seg;
   endfunction

   // Digit N-1 lands in the top byte so it leaves the shifter first.
   always_comb begin
      w_enc_frame = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_enc_frame[8*i +: 8] = seg_encode(r_dig_cap[4*i +: 4], r_dp_cap[i]);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_div_next   = '0;
      w_bit_next   = r_bit;
      w_frame_next = r_frame;
      w_capture    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_capture    = 1'b1;
               w_state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            w_frame_next = w_enc_frame;
            w_bit_next   = '0;
            w_state_next = S_SHIFT_LO;
         end
         S_SHIFT_LO: begin
            if (r_div == DIV_LAST) begin
               w_state_next = S_SHIFT_HI;
            end else begin
               w_div_next = r_div + 1'b1;
            end
         end
         S_SHIFT_HI: begin
            if (r_div == DIV_LAST) begin
               w_bit_next   = r_bit + 1'b1;
               w_frame_next = {r_frame[NBITS-2:0], 1'b0};
               w_state_next = (r_bit == BIT_LAST) ? S_LATCH : S_SHIFT_LO;
            end else begin
               w_div_next = r_div + 1'b1;
            end
         end
         S_LATCH: begin
            if (r_div == LATCH_LAST) begin
               w_state_next = S_DONE;
            end else begin
               w_div_next = r_div + 1'b1;
            end
         end
         S_DONE: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase

      // Pin values are decoded from the next state and registered, so the
      // 595 clocks come straight from flops and cannot glitch.
      w_srclk_next = (w_state_next == S_SHIFT_HI);
      w_rclk_next  = (w_state_next == S_LATCH) && (w_div_next < DIV_HALF);
      w_ser_next   = ((w_state_next == S_SHIFT_LO) || (w_state_next == S_SHIFT_HI))
                     && w_frame_next[NBITS-1];
      w_busy_next  = (w_state_next == S_LOAD) || (w_state_next == S_SHIFT_LO)
                     || (w_state_next == S_SHIFT_HI) || (w_state_next == S_LATCH);
      w_done_next  = (w_state_next == S_DONE);
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_div     <= '0;
         r_bit     <= '0;
         r_ser     <= 1'b0;
         r_srclk   <= 1'b0;
         r_rclk    <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_srclr_n <= 1'b0;
         r_oe_n    <= 1'b1;
      end else begin
         r_div     <= w_div_next;
         r_bit     <= w_bit_next;
         r_ser     <= w_ser_next;
         r_srclk   <= w_srclk_next;
         r_rclk    <= w_rclk_next;
         r_busy    <= w_busy_next;
         r_done    <= w_done_next;
         r_srclr_n <= 1'b1;
         r_oe_n    <= blank;
      end
   end

   always_ff @(posedge CLK) begin
      r_frame <= w_frame_next;
      if (w_capture) begin
         r_dig_cap <= digits;
         r_dp_cap  <= dp;
      end
   end

   assign SER      = r_ser;
   assign SRCLK    = r_srclk;
   assign RCLK     = r_rclk;
   assign busy     = r_busy;
   assign done     = r_done;
   assign SRCLRbar = r_srclr_n;
   assign OEbar    = r_oe_n;

endmodule

// File: tb/tb_hc595_chain_display_driver.sv
// Drives three driver configurations and checks them against a behavioural
// model of the 595 chain (shift on SRCLK rise, copy on RCLK rise).
module tb_hc595_chain_display_driver;

   localparam logic [7:0] SEG_TBL [16] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hE6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       RST;
   logic       start_ab, blank_ab, start_c, blank_c, dp_c;
   logic [7:0] dig_ab;
   logic [1:0] dp_ab;
   logic [3:0] dig_c;

   logic busy_a, done_a, ser_a, srclk_a, rclk_a, clr_a, oe_a;
   logic busy_b, done_b, ser_b, srclk_b, rclk_b, clr_b, oe_b;
   logic busy_c, done_c, ser_c, srclk_c, rclk_c, clr_c, oe_c;

   hc595_chain_display_driver #(.NUM_DIGITS(2), .CLK_DIV(2), .COMMON_ANODE(0)) u_a (
      .CLK(clk), .RST(RST), .start(start_ab), .digits(dig_ab), .dp(dp_ab), .blank(blank_ab),
      .busy(busy_a), .done(done_a), .SER(ser_a), .SRCLK(srclk_a), .RCLK(rclk_a),
      .SRCLRbar(clr_a), .OEbar(oe_a));

   hc595_chain_display_driver #(.NUM_DIGITS(2), .CLK_DIV(2), .COMMON_ANODE(1)) u_b (
      .CLK(clk), .RST(RST), .start(start_ab), .digits(dig_ab), .dp(dp_ab), .blank(blank_ab),
      .busy(busy_b), .done(done_b), .SER(ser_b), .SRCLK(srclk_b), .RCLK(rclk_b),
      .SRCLRbar(clr_b), .OEbar(oe_b));

   hc595_chain_display_driver #(.NUM_DIGITS(1), .CLK_DIV(1), .COMMON_ANODE(0)) u_c (
      .CLK(clk), .RST(RST), .start(start_c), .digits(dig_c), .dp(dp_c), .blank(blank_c),
      .busy(busy_c), .done(done_c), .SER(ser_c), .SRCLK(srclk_c), .RCLK(rclk_c),
      .SRCLRbar(clr_c), .OEbar(oe_c));

   logic [2:0] m_busy, m_done, m_ser, m_srclk, m_rclk, m_clr;
   assign m_busy  = {busy_c, busy_b, busy_a};
   assign m_done  = {done_c, done_b, done_a};
   assign m_ser   = {ser_c, ser_b, ser_a};
   assign m_srclk = {srclk_c, srclk_b, srclk_a};
   assign m_rclk  = {rclk_c, rclk_b, rclk_a};
   assign m_clr   = {clr_c, clr_b, clr_a};

   // Cumulative per-instance observations, sampled on the falling edge.
   int          busy_n [3] = '{0, 0, 0};
   int          done_n [3] = '{0, 0, 0};
   int          sr_n   [3] = '{0, 0, 0};
   int          rc_n   [3] = '{0, 0, 0};
   int          ovl_n      = 0;
   int          unst_n     = 0;
   logic [15:0] chain  [3] = '{16'h0, 16'h0, 16'h0};
   logic [15:0] latched[3] = '{16'h0, 16'h0, 16'h0};
   logic [2:0]  p_srclk = 3'b0, p_rclk = 3'b0, p_ser = 3'b0;

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (m_busy[k] === 1'b1) busy_n[k]++;
         if (m_done[k] === 1'b1) done_n[k]++;
         if (m_srclk[k] === 1'b1 && m_rclk[k] === 1'b1) ovl_n++;
         if (m_srclk[k] === 1'b1 && m_ser[k] !== p_ser[k]) unst_n++;
         if (m_srclk[k] === 1'b1 && p_srclk[k] === 1'b0) begin
            sr_n[k]++;
            chain[k] = {chain[k][14:0], m_ser[k]};
         end
         if (m_rclk[k] === 1'b1 && p_rclk[k] === 1'b0) begin
            rc_n[k]++;
            latched[k] = chain[k];
         end
         if (m_clr[k] === 1'b0) chain[k] = 16'h0;
      end
      p_srclk = m_srclk;
      p_rclk  = m_rclk;
      p_ser   = m_ser;
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] enc(input logic [3:0] v, input logic d, input bit ca);
      logic [7:0] s;
      s = SEG_TBL[v] | {7'b0, d};
      return ca ? ~s : s;
   endfunction

   task automatic run_ab(input logic [7:0] d, input logic [1:0] p, input int hold,
                         input bit disturb, input bit blank_test, input bit start_in_done);
      int s_busy0, s_busy1, s_done0, s_done1, s_sr0, s_sr1, s_rc0, s_rc1, n;
      s_busy0 = busy_n[0]; s_busy1 = busy_n[1];
      s_done0 = done_n[0]; s_done1 = done_n[1];
      s_sr0 = sr_n[0]; s_sr1 = sr_n[1]; s_rc0 = rc_n[0]; s_rc1 = rc_n[1];
      dig_ab = d; dp_ab = p; start_ab = 1'b1;
      for (int i = 0; i < hold; i++) tick();
      start_ab = 1'b0;
      if (disturb) begin
         dig_ab = 8'($urandom); dp_ab = 2'($urandom);
         for (int i = 0; i < 6; i++) tick();
         start_ab = 1'b1; tick(); start_ab = 1'b0;
      end
      if (blank_test) begin
         tick();
         blank_ab = 1'b1;
         check("oe_before_blank", 32'(oe_a), 32'd0);
         tick();
         check("oe_blank_a", 32'(oe_a), 32'd1);
         check("oe_blank_b", 32'(oe_b), 32'd1);
         blank_ab = 1'b0;
         tick();
         check("oe_unblank", 32'(oe_a), 32'd0);
      end
      n = 0;
      while (done_a !== 1'b1 && n < 400) begin tick(); n++; end
      check("ab_done_seen", 32'(n < 400), 32'd1);
      if (start_in_done) begin
         start_ab = 1'b1; tick(); start_ab = 1'b0;
         for (int i = 0; i < 6; i++) tick();
         check("start_in_done_idle", 32'(busy_a), 32'd0);
      end else begin
         for (int i = 0; i < 3; i++) tick();
      end
      check("a_frame", 32'(latched[0]), 32'({enc(d[7:4], p[1], 0), enc(d[3:0], p[0], 0)}));
      check("b_frame", 32'(latched[1]), 32'({enc(d[7:4], p[1], 1), enc(d[3:0], p[0], 1)}));
      check("a_busy_cycles", busy_n[0] - s_busy0, 32'd69);
      check("b_busy_cycles", busy_n[1] - s_busy1, 32'd69);
      check("a_srclk_edges", sr_n[0] - s_sr0, 32'd16);
      check("b_srclk_edges", sr_n[1] - s_sr1, 32'd16);
      check("a_rclk_edges", rc_n[0] - s_rc0, 32'd1);
      check("b_rclk_edges", rc_n[1] - s_rc1, 32'd1);
      check("a_done_pulses", done_n[0] - s_done0, 32'd1);
      check("b_done_pulses", done_n[1] - s_done1, 32'd1);
   endtask

   task automatic run_c(input logic [3:0] v, input logic p);
      int s_busy, s_done, s_sr, s_rc, n;
      s_busy = busy_n[2]; s_done = done_n[2]; s_sr = sr_n[2]; s_rc = rc_n[2];
      dig_c = v; dp_c = p; start_c = 1'b1;
      tick();
      start_c = 1'b0;
      n = 0;
      while (done_c !== 1'b1 && n < 100) begin tick(); n++; end
      tick();
      check("c_frame", 32'(latched[2][7:0]), 32'(enc(v, p, 0)));
      check("c_busy_cycles", busy_n[2] - s_busy, 32'd19);
      check("c_srclk_edges", sr_n[2] - s_sr, 32'd8);
      check("c_rclk_edges", rc_n[2] - s_rc, 32'd1);
      check("c_done_pulses", done_n[2] - s_done, 32'd1);
   endtask

   initial begin
      int          s_sr, s_rc, n;
      logic [15:0] lat0;
      RST = 1'b1;
      start_ab = 1'b0; blank_ab = 1'b0; dig_ab = 8'h0; dp_ab = 2'b0;
      start_c = 1'b0; blank_c = 1'b0; dig_c = 4'h0; dp_c = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      check("rst_ser", 32'(ser_a), 32'd0);
      check("rst_srclk", 32'(srclk_a), 32'd0);
      check("rst_rclk", 32'(rclk_a), 32'd0);
      check("rst_srclr", 32'(clr_a), 32'd0);
      check("rst_oe", 32'(oe_a), 32'd1);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_done", 32'(done_a), 32'd0);
      check("rst_oe_c", 32'(oe_c), 32'd1);
      RST = 1'b0;
      tick();
      check("srclr_release_a", 32'(clr_a), 32'd1);
      check("srclr_release_c", 32'(clr_c), 32'd1);
      check("oe_release", 32'(oe_a), 32'd0);

      run_ab(8'h3A, 2'b00, 1, 0, 0, 0);
      run_ab(8'h08, 2'b01, 1, 0, 0, 0);
      run_ab(8'($urandom), 2'($urandom), 10, 1, 1, 1);

      // Abort a frame part way through the shift.
      lat0 = latched[0]; s_sr = sr_n[0]; s_rc = rc_n[0];
      dig_ab = 8'($urandom); start_ab = 1'b1; tick(); start_ab = 1'b0;
      n = 0;
      while (sr_n[0] - s_sr < 5 && n < 200) begin tick(); n++; end
      RST = 1'b1;
      tick();
      check("abort_srclk", 32'(srclk_a), 32'd0);
      check("abort_rclk", 32'(rclk_a), 32'd0);
      check("abort_ser", 32'(ser_a), 32'd0);
      check("abort_busy", 32'(busy_a), 32'd0);
      check("abort_srclr", 32'(clr_a), 32'd0);
      check("abort_oe", 32'(oe_a), 32'd1);
      check("abort_b_busy", 32'(busy_b), 32'd0);
      tick();
      RST = 1'b0;
      tick();
      tick();
      check("abort_no_rclk", rc_n[0] - s_rc, 32'd0);
      check("abort_latched_kept", 32'(latched[0]), 32'(lat0));
      run_ab(8'($urandom), 2'($urandom), 1, 0, 0, 0);

      for (int f = 0; f < 5; f++) begin
         run_ab(8'($urandom), 2'($urandom), $urandom_range(1, 4), 1'($urandom),
                1'($urandom), 1'($urandom));
      end

      for (int v = 0; v < 16; v++) begin
         run_c(4'(v), (v < 8) ? 1'b0 : 1'($urandom));
      end

      check("srclk_rclk_overlap", ovl_n, 32'd0);
      check("ser_stable_while_srclk_high", unst_n, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
